// File: rtl/bram_result_writer.sv
// Burst writer: takes len producer words and writes them to consecutive BRAM addresses from base_addr.
// Optional macro BRAM_WRITE_VERIFY_EN reads each word back and checks it before accepting the next one.
module bram_result_writer #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY  = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERROR = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              words_left;
  logic              verify_busy;
  logic              accept;

  // words_written doubles as the accepted-word count: it moves on the edge that accepts a word.
  assign words_left = (ww_q < len_q);
  assign accept     = in_valid & in_ready;

`ifdef BRAM_WRITE_VERIFY_EN
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic              rd_now;
  logic              cmp_now;
  logic              cmp_ok;

  assign rd_now      = ena_q & ~wea_q;
  assign cmp_now     = pipe_q[RD_LAT-1];
  assign cmp_ok      = (bram_douta == dina_q);
  assign verify_busy = ena_q | (|pipe_q);
  assign pipe_d      = RD_LAT'({pipe_q, rd_now});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{bram_douta, 2'(RD_LAT)};
  assign verify_busy = 1'b0;
`endif

  assign in_ready      = (state_q == ST_BUSY) && words_left && !verify_busy;
  assign bram_ena      = ena_q;
  assign bram_wea      = wea_q;
  assign bram_addra    = addra_q;
  assign bram_dina     = dina_q;
  assign state         = state_q;
  assign words_written = ww_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ww_d    = ww_q;
    ena_d   = 1'b0;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    case (state_q)
      ST_BUSY: begin
        if (accept) begin
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = addr_q;
          dina_d  = in_data;
          addr_d  = addr_q + ADDR_W'(1);
          ww_d    = ww_q + (ADDR_W+1)'(1);
        end
`ifdef BRAM_WRITE_VERIFY_EN
        // Read-back reuses the held address/data registers of the write just issued.
        if (wea_q) begin
          ena_d = 1'b1;
        end
        if (cmp_now) begin
          if (!cmp_ok) begin
            state_d = ST_ERROR;
            ww_d    = ww_q - (ADDR_W+1)'(1);
          end else if (!words_left) begin
            state_d = ST_DONE;
          end
        end
`else
        if (wea_q && !words_left) begin
          state_d = ST_DONE;
        end
`endif
      end
      default: begin
        if (start) begin
          addr_d  = base_addr;
          len_d   = len;
          ww_d    = '0;
          state_d = (len == '0) ? ST_DONE : ST_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      ww_q    <= '0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ww_q    <= ww_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

endmodule

// File: tb/tb_bram_result_writer.sv
// Directed bench for bram_result_writer; with BRAM_WRITE_VERIFY_EN it runs the corrupted read-back case.
module tb_bram_result_writer;
  localparam int DATA_W = 11;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              bram_ena;
  logic              bram_wea;
  logic [ADDR_W-1:0] bram_addra;
  logic [DATA_W-1:0] bram_dina;
  logic [DATA_W-1:0] bram_douta = '0;
  logic [2:0]        state;
  logic [ADDR_W:0]   words_written;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0, ena_cnt = 0, wr01_cnt = 0, acc3_cnt = 0, rdy_cnt = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  bram_result_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_douta(bram_douta), .state(state),
    .words_written(words_written)
  );

  // BRAM model with one-cycle read latency; address 0x02 reads back with bit 0 flipped.
  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_wea) mem[bram_addra] <= bram_dina;
      bram_douta <= mem[bram_addra] ^ ((bram_addra == 8'h02) ? 11'h001 : 11'h000);
    end
  end

  always @(negedge clk) begin
    if (bram_ena) ena_cnt++;
    if (bram_ena && bram_wea) wr_cnt++;
    if (bram_ena && bram_wea && bram_addra == 8'h01) wr01_cnt++;
    if (bram_ena && bram_addra == 8'h03) acc3_cnt++;
    if (in_ready) rdy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_ena_wea"}, 32'({bram_ena, bram_wea}), 0);
    chk({tag, "_addra"}, 32'(bram_addra), 0);
    chk({tag, "_dina"}, 32'(bram_dina), 0);
    chk({tag, "_ww"}, 32'(words_written), 0);
  endtask

  // Back-to-back burst with in_valid held high; each write must follow its acceptance by one cycle.
  task automatic burst(input logic [7:0] base, input int n, input logic [10:0] d0);
    start = 1'b1; base_addr = base; len = 9'(n);
    tick();
    start = 1'b0;
    chk("burst_busy", 32'(state), 1);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = d0 + 11'(i);
      chk("burst_in_ready", 32'(in_ready), 1);
      tick();
      chk("burst_wr_ena_wea", 32'({bram_ena, bram_wea}), 32'h3);
      chk("burst_wr_addr", 32'(bram_addra), 32'(8'(base + 8'(i))));
      chk("burst_wr_data", 32'(bram_dina), 32'(d0 + 11'(i)));
      chk("burst_ww", 32'(words_written), 32'(i + 1));
    end
    chk("burst_in_ready_drop", 32'(in_ready), 0);
    in_valid = 1'b0;
    tick();
    chk("burst_done", 32'(state), 2);
    chk("burst_done_ena", 32'(bram_ena), 0);
    chk("burst_done_ww", 32'(words_written), 32'(n));
  endtask

  initial begin
    int w0, w1, e0, r0, a0;
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick();
    chk_reset_outputs("held_reset");
    #2 reset = 1'b1;
    tick();
    chk("post_reset_state", 32'(state), 0);
    chk("post_reset_in_ready", 32'(in_ready), 0);

`ifndef BRAM_WRITE_VERIFY_EN
    // base 0x10, four words 0x001..0x004
    burst(8'h10, 4, 11'h001);
    tick();
    chk("s1_done_hold", 32'(state), 2);
    chk("s1_idle_ena", 32'(bram_ena), 0);

    // wrap 0xFE, 0xFF, 0x00 and nothing at 0x01
    w0 = wr_cnt; w1 = wr01_cnt;
    burst(8'hFE, 3, 11'h100);
    tick(); tick();
    chk("s2_write_count", 32'(wr_cnt - w0), 3);
    chk("s2_no_write_01", 32'(wr01_cnt - w1), 0);

    // len = 0
    e0 = ena_cnt; r0 = rdy_cnt;
    start = 1'b1; base_addr = 8'h33; len = 9'd0;
    tick();
    start = 1'b0;
    chk("s3_done", 32'(state), 2);
    chk("s3_in_ready", 32'(in_ready), 0);
    chk("s3_ww", 32'(words_written), 0);
    tick(); tick();
    chk("s3_no_ena", 32'(ena_cnt - e0), 0);
    chk("s3_no_ready", 32'(rdy_cnt - r0), 0);

    // in_valid 1,0,1,0 with len 2, start pulsed during BUSY
    w0 = wr_cnt;
    start = 1'b1; base_addr = 8'h40; len = 9'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 11'h0AA;
    chk("s4_ready0", 32'(in_ready), 1);
    tick();
    chk("s4_wr0_ena_wea", 32'({bram_ena, bram_wea}), 32'h3);
    chk("s4_wr0_addr", 32'(bram_addra), 32'h40);
    chk("s4_wr0_data", 32'(bram_dina), 32'h0AA);
    chk("s4_wr0_ww", 32'(words_written), 1);
    in_valid = 1'b0; start = 1'b1; base_addr = 8'h77; len = 9'd5;
    tick();
    start = 1'b0;
    chk("s4_gap_ena", 32'(bram_ena), 0);
    chk("s4_gap_state", 32'(state), 1);
    chk("s4_gap_ww", 32'(words_written), 1);
    in_valid = 1'b1; in_data = 11'h055;
    tick();
    chk("s4_wr1_ena_wea", 32'({bram_ena, bram_wea}), 32'h3);
    chk("s4_wr1_addr", 32'(bram_addra), 32'h41);
    chk("s4_wr1_data", 32'(bram_dina), 32'h055);
    chk("s4_wr1_ww", 32'(words_written), 2);
    in_valid = 1'b0;
    tick();
    chk("s4_done", 32'(state), 2);
    chk("s4_done_ena", 32'(bram_ena), 0);
    chk("s4_write_count", 32'(wr_cnt - w0), 2);

    // reset after 2 of 5 words
    start = 1'b1; base_addr = 8'h20; len = 9'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 11'h0A1;
    tick();
    in_data = 11'h0A2;
    tick();
    chk("s5_wr2_addr", 32'(bram_addra), 32'h21);
    chk("s5_wr2_ww", 32'(words_written), 2);
    in_data = 11'h0A3;
    #1 reset = 1'b0;
    #1;
    chk_reset_outputs("s5_mid_reset");
    w0 = wr_cnt; e0 = ena_cnt;
    tick();
    #2 reset = 1'b1;
    tick(); tick(); tick();
    chk("s5_idle_state", 32'(state), 0);
    chk("s5_idle_ready", 32'(in_ready), 0);
    chk("s5_no_writes", 32'(wr_cnt - w0), 0);
    chk("s5_no_ena", 32'(ena_cnt - e0), 0);
    in_valid = 1'b0;
`else
    // base 0x00, len 4; read-back of address 0x02 is corrupted
    a0 = acc3_cnt;
    start = 1'b1; base_addr = 8'h00; len = 9'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 60 && state == 3'd1; k++) begin
      in_data = 11'h300 + 11'(words_written);
      tick();
    end
    in_valid = 1'b0;
    chk("s6_error_state", 32'(state), 3);
    chk("s6_ww", 32'(words_written), 2);
    tick(); tick();
    chk("s6_error_hold", 32'(state), 3);
    chk("s6_no_ena", 32'(bram_ena), 0);
    chk("s6_no_access_03", 32'(acc3_cnt - a0), 0);
    chk("s6_in_ready", 32'(in_ready), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
